// File: rtl/vr_pkg.sv
// Shared types and sizing helpers for the valid/ready pipeline chain.
package vr_pkg;

   typedef struct packed {
      logic main_v;
      logic skid_v;
   } slice_state_t;

   function automatic int occ_width(input int stages, input int reg_ready);
      return $clog2(stages * (1 + reg_ready) + 1);
   endfunction

endpackage

// File: rtl/vr_skid_slice.sv
// One valid/ready register slice: skid buffer (registered ready, cap 2) or forward register (comb ready, cap 1).
// Latency 1 cycle; REG_READY=1 drops up_ready when its skid entry is occupied, REG_READY=0 passes dn_ready through.
module vr_skid_slice
   import vr_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int REG_READY = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic [WIDTH-1:0] up_data,
   input  logic             up_valid,
   output logic             up_ready,
   output logic [WIDTH-1:0] dn_data,
   output logic             dn_valid,
   input  logic             dn_ready
);

   generate
      if (REG_READY != 0) begin : g_skid
         slice_state_t     st;
         slice_state_t     st_n;
         logic [WIDTH-1:0] main_d;
         logic [WIDTH-1:0] skid_d;
         logic             rdy_q;
         logic             in_fire;
         logic             out_fire;

         assign in_fire  = up_valid & rdy_q;
         assign out_fire = st.main_v & dn_ready;

         // in_fire never coincides with a full skid, since rdy_q mirrors ~skid_v
         always_comb begin
            st_n = st;
            if (out_fire) begin
               if (st.skid_v) begin
                  st_n.main_v = 1'b1;
                  st_n.skid_v = 1'b0;
               end else begin
                  st_n.main_v = in_fire;
               end
            end else if (in_fire) begin
               if (st.main_v) st_n.skid_v = 1'b1;
               else           st_n.main_v = 1'b1;
            end
            if (flush) st_n = '0;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               st    <= '0;
               rdy_q <= 1'b0;
            end else begin
               st    <= st_n;
               rdy_q <= ~st_n.skid_v;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               main_d <= '0;
               skid_d <= '0;
            end else begin
               if (out_fire && st.skid_v)                  main_d <= skid_d;
               else if (in_fire && (!st.main_v || out_fire)) main_d <= up_data;
               if (in_fire && st.main_v && !out_fire)      skid_d <= up_data;
            end
         end

         assign up_ready = rdy_q;
         assign dn_data  = main_d;
         assign dn_valid = st.main_v;
      end else begin : g_fwd
         slice_state_t     st;
         logic [WIDTH-1:0] main_d;
         logic             in_fire;
         logic             out_fire;

         assign up_ready = dn_ready | ~st.main_v;
         assign in_fire  = up_valid & up_ready;
         assign out_fire = st.main_v & dn_ready;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               st <= '0;
            end else if (flush) begin
               st <= '0;
            end else if (in_fire) begin
               st.main_v <= 1'b1;
            end else if (out_fire) begin
               st.main_v <= 1'b0;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)       main_d <= '0;
            else if (in_fire) main_d <= up_data;
         end

         assign dn_data  = main_d;
         assign dn_valid = st.main_v;
      end
   endgenerate

endmodule

// File: rtl/vr_pipe_chain.sv
// STAGES-deep valid/ready retiming chain with synchronous flush and a registered occupancy count.
// Latency STAGES cycles; backpressure ripples one slice per cycle (REG_READY=1) or combinationally (REG_READY=0).
module vr_pipe_chain
   import vr_pkg::*;
#(
   parameter  int WIDTH     = 32,
   parameter  int STAGES    = 2,
   parameter  int REG_READY = 1,
   localparam int OCC_W     = occ_width(STAGES, REG_READY)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid_up_in,
   input  logic             ready_down_in,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_down_out,
   output logic             ready_up_out,
   output logic [OCC_W-1:0] occupancy
);

   logic [WIDTH-1:0] stage_d [STAGES+1];
   logic [STAGES:0]  stage_v;
   logic [STAGES:0]  stage_r;
   logic             up_fire;
   logic             down_fire;

   assign stage_d[0]      = data_in;
   assign stage_v[0]      = valid_up_in;
   assign ready_up_out    = stage_r[0];
   assign data_out        = stage_d[STAGES];
   assign valid_down_out  = stage_v[STAGES];
   assign stage_r[STAGES] = ready_down_in;

   genvar i;
   generate
      for (i = 0; i < STAGES; i++) begin : g_stage
         vr_skid_slice #(
            .WIDTH     (WIDTH),
            .REG_READY (REG_READY)
         ) u_slice (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .up_data  (stage_d[i]),
            .up_valid (stage_v[i]),
            .up_ready (stage_r[i]),
            .dn_data  (stage_d[i+1]),
            .dn_valid (stage_v[i+1]),
            .dn_ready (stage_r[i+1])
         );
      end
   endgenerate

   assign up_fire   = valid_up_in & ready_up_out;
   assign down_fire = valid_down_out & ready_down_in;

   // A flushed cycle discards the up-beat and empties the chain, so the count restarts at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occupancy <= '0;
      end else if (flush) begin
         occupancy <= '0;
      end else if (up_fire && !down_fire) begin
         occupancy <= occupancy + OCC_W'(1);
      end else if (down_fire && !up_fire) begin
         occupancy <= occupancy - OCC_W'(1);
      end
   end

endmodule

// File: tb/tb_vr_pipe_chain.sv
// Directed and randomised checks of vr_pipe_chain: a 3-stage skid chain (A) and a 1-stage forward register (B) share stimulus.
module tb_vr_pipe_chain;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic [31:0] data_in;
   logic        valid_up_in;
   logic        ready_down_in;

   logic [31:0] a_data;
   logic        a_valid;
   logic        a_ready;
   logic [2:0]  a_occ;
   logic [31:0] b_data;
   logic        b_valid;
   logic        b_ready;
   logic [0:0]  b_occ;

   int n_pass  = 0;
   int n_total = 0;

   vr_pipe_chain #(.WIDTH(32), .STAGES(3), .REG_READY(1)) u_dut_a (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush          (flush),
      .data_in        (data_in),
      .valid_up_in    (valid_up_in),
      .ready_down_in  (ready_down_in),
      .data_out       (a_data),
      .valid_down_out (a_valid),
      .ready_up_out   (a_ready),
      .occupancy      (a_occ)
   );

   vr_pipe_chain #(.WIDTH(32), .STAGES(1), .REG_READY(0)) u_dut_b (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush          (flush),
      .data_in        (data_in),
      .valid_up_in    (valid_up_in),
      .ready_down_in  (ready_down_in),
      .data_out       (b_data),
      .valid_down_out (b_valid),
      .ready_up_out   (b_ready),
      .occupancy      (b_occ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #6_000_000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   logic [31:0] qa[$];
   logic [31:0] qb[$];
   logic        a_hold, b_hold;
   logic [31:0] a_hd, b_hd;
   int          acc;

   initial begin
      // reset with live-looking inputs
      rst_n = 1'b0; flush = 1'b0; data_in = 32'hDEADBEEF; valid_up_in = 1'b1; ready_down_in = 1'b1;
      repeat (2) tick();
      chk("rst_a_data", a_data, 0);
      chk("rst_a_valid", a_valid, 0);
      chk("rst_a_ready", a_ready, 0);
      chk("rst_a_occ", a_occ, 0);
      chk("rst_b_valid", b_valid, 0);
      chk("rst_b_ready", b_ready, 1);
      valid_up_in = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("rel_a_ready_pre", a_ready, 0);
      tick();
      chk("rel_a_ready_post", a_ready, 1);

      // streaming 0x1..0x10: beat accepted at edge c shows after edge c+2
      ready_down_in = 1'b1;
      for (int c = 0; c < 19; c++) begin
         data_in     = 32'(c + 1);
         valid_up_in = (c < 16);
         tick();
         if (c >= 2 && c <= 17) begin
            chk("str_valid", a_valid, 1);
            chk("str_data", a_data, 64'(c - 1));
         end
         if (c >= 2 && c <= 15) chk("str_occ", a_occ, 3);
         if (c <= 15) chk("str_ready", a_ready, 1);
      end
      chk("str_end_valid", a_valid, 0);
      chk("str_end_occ", a_occ, 0);

      // backpressure: fill until ready drops
      ready_down_in = 1'b0;
      valid_up_in   = 1'b1;
      acc = 0;
      while (a_ready && acc < 20) begin
         data_in = 32'h100 + 32'(acc);
         tick();
         acc++;
      end
      valid_up_in = 1'b0;
      chk("bp_accepted", acc, 6);
      chk("bp_occ", a_occ, 6);
      chk("bp_ready", a_ready, 0);
      ready_down_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("bp_drain_valid", a_valid, 1);
         chk("bp_drain_data", a_data, 64'h100 + 64'(i));
         tick();
         if (i == 0) begin
            chk("bp_ready_after1", a_ready, 0);
            chk("bp_occ_after1", a_occ, 5);
         end
         if (i == 2) chk("bp_ready_after3", a_ready, 1);
      end
      chk("bp_empty_valid", a_valid, 0);
      chk("bp_empty_occ", a_occ, 0);

      // flush with four beats held and an up-fire in the same cycle
      ready_down_in = 1'b0;
      valid_up_in   = 1'b1;
      for (int n = 0; n < 4; n++) begin
         data_in = 32'h200 + 32'(n);
         tick();
      end
      chk("fl_occ_pre", a_occ, 4);
      chk("fl_ready_pre", a_ready, 1);
      chk("fl_valid_pre", a_valid, 1);
      chk("fl_data_pre", a_data, 64'h200);
      data_in = 32'h2FF; flush = 1'b1; ready_down_in = 1'b1;
      tick();
      flush = 1'b0; valid_up_in = 1'b0;
      chk("fl_valid", a_valid, 0);
      chk("fl_occ", a_occ, 0);
      chk("fl_ready", a_ready, 1);
      chk("fl_b_valid", b_valid, 0);
      chk("fl_b_occ", b_occ, 0);
      for (int n = 0; n < 4; n++) begin
         tick();
         chk("fl_no_ghost", a_valid, 0);
      end

      // forward-register slice: hold one beat, then simultaneous in/out fire
      ready_down_in = 1'b0; valid_up_in = 1'b1; data_in = 32'h300;
      #1;
      chk("b_ready_empty", b_ready, 1);
      tick();
      chk("b_held_valid", b_valid, 1);
      chk("b_held_data", b_data, 64'h300);
      chk("b_held_ready", b_ready, 0);
      chk("b_held_occ", b_occ, 1);
      ready_down_in = 1'b1; data_in = 32'h301;
      #1;
      chk("b_ready_comb", b_ready, 1);
      tick();
      chk("b_swap_occ", b_occ, 1);
      chk("b_swap_data", b_data, 64'h301);
      chk("b_swap_valid", b_valid, 1);
      valid_up_in = 1'b0;
      repeat (8) tick();
      chk("pre_rand_a_occ", a_occ, 0);
      chk("pre_rand_b_occ", b_occ, 0);

      // random valid/ready at 50% against per-DUT scoreboards
      a_hold = 1'b0; b_hold = 1'b0; a_hd = '0; b_hd = '0;
      for (int c = 0; c < 40000; c++) begin
         valid_up_in   = 1'($urandom_range(0, 1));
         ready_down_in = 1'($urandom_range(0, 1));
         data_in       = $urandom;
         #1;
         if (a_hold) begin
            chk("a_hold_valid", a_valid, 1);
            chk("a_hold_data", a_data, a_hd);
         end
         if (b_hold) begin
            chk("b_hold_valid", b_valid, 1);
            chk("b_hold_data", b_data, b_hd);
         end
         if (a_valid && ready_down_in) begin
            chk("a_nonempty", qa.size() != 0, 1);
            if (qa.size() != 0) begin
               chk("a_order", a_data, qa[0]);
               qa.delete(0);
            end
         end
         if (b_valid && ready_down_in) begin
            chk("b_nonempty", qb.size() != 0, 1);
            if (qb.size() != 0) begin
               chk("b_order", b_data, qb[0]);
               qb.delete(0);
            end
         end
         if (valid_up_in && a_ready) qa.push_back(data_in);
         if (valid_up_in && b_ready) qb.push_back(data_in);
         a_hold = a_valid && !ready_down_in; a_hd = a_data;
         b_hold = b_valid && !ready_down_in; b_hd = b_data;
         tick();
         chk("a_occ_model", a_occ, 64'(qa.size()));
         chk("b_occ_model", b_occ, 64'(qb.size()));
      end

      // drain the rest and confirm every accepted beat emerged in order
      valid_up_in = 1'b0; ready_down_in = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (a_valid) begin
            chk("a_drain_nonempty", qa.size() != 0, 1);
            if (qa.size() != 0) begin
               chk("a_drain_order", a_data, qa[0]);
               qa.delete(0);
            end
         end
         if (b_valid) begin
            chk("b_drain_nonempty", qb.size() != 0, 1);
            if (qb.size() != 0) begin
               chk("b_drain_order", b_data, qb[0]);
               qb.delete(0);
            end
         end
         tick();
      end
      chk("a_all_delivered", qa.size(), 0);
      chk("b_all_delivered", qb.size(), 0);
      chk("a_final_occ", a_occ, 0);

      // asynchronous reset in the middle of traffic
      ready_down_in = 1'b0; valid_up_in = 1'b1; data_in = 32'h400;
      repeat (4) tick();
      chk("mid_occ_pre", a_occ, 4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", a_valid, 0);
      chk("mid_rst_data", a_data, 0);
      chk("mid_rst_occ", a_occ, 0);
      chk("mid_rst_ready", a_ready, 0);
      chk("mid_rst_b_ready", b_ready, 1);
      chk("mid_rst_b_occ", b_occ, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
